// File: rtl/div_if.sv
// Start/cancel/stop handshake and operand/result bus between the execute stage and the divider.
interface div_if #(
   parameter int DATA_W = 32
);
   logic              div_start;
   logic              div_cancel;
   logic              div_signed;
   logic [DATA_W-1:0] div_op1;
   logic [DATA_W-1:0] div_op2;
   logic              div_busy;
   logic              div_stop;
   logic [DATA_W-1:0] div_quo;
   logic [DATA_W-1:0] div_rem;

   modport master (
      output div_start, div_cancel, div_signed, div_op1, div_op2,
      input  div_busy, div_stop, div_quo, div_rem
   );

   modport slave (
      input  div_start, div_cancel, div_signed, div_op1, div_op2,
      output div_busy, div_stop, div_quo, div_rem
   );
endinterface

// File: rtl/div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow straight after start.
//
// state | meaning
// IDLE  | waiting for an accepted start
// BUSY  | one restoring iteration per cycle, DATA_W in total
// DONE  | results valid, stop pulse high for this cycle
module div #(
   parameter int DATA_W = 32
) (
   input logic clk,
   input logic rst_n,
   div_if.slave bus
);
   localparam int CW = $clog2(DATA_W) + 1;
   localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] dvs_q;
   logic [DATA_W-1:0] op1_q;
   logic              sgn_q;
   logic              qsign_q;
   logic              rsign_q;
   logic              dbz_q;
   logic              ovf_q;
   logic              busy_q;
   logic              stop_q;

   logic [DATA_W-1:0] mag1;
   logic [DATA_W-1:0] mag2;
   logic              start_dbz;
   logic              start_ovf;
   logic [DATA_W:0]   partial;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] quo_out;
   logic [DATA_W-1:0] rem_out;

   always_comb begin
      mag1      = (bus.div_signed && bus.div_op1[DATA_W-1]) ? -bus.div_op1 : bus.div_op1;
      mag2      = (bus.div_signed && bus.div_op2[DATA_W-1]) ? -bus.div_op2 : bus.div_op2;
      start_dbz = (bus.div_op2 == '0);
      start_ovf = bus.div_signed && (bus.div_op1 == MIN_VAL) && (bus.div_op2 == '1);
      // rem_q < divisor always holds, so DATA_W+1 bits suffice for the sign of the trial
      partial   = {rem_q, quo_q[DATA_W-1]};
      diff      = partial - {1'b0, dvs_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         op1_q   <= '0;
         sgn_q   <= 1'b0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         stop_q  <= 1'b0;
      end else if (bus.div_cancel) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         stop_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               stop_q <= 1'b0;
               if (bus.div_start) begin
                  quo_q   <= mag1;
                  dvs_q   <= mag2;
                  op1_q   <= bus.div_op1;
                  rem_q   <= '0;
                  cnt     <= '0;
                  sgn_q   <= bus.div_signed;
                  qsign_q <= bus.div_op1[DATA_W-1] ^ bus.div_op2[DATA_W-1];
                  rsign_q <= bus.div_op1[DATA_W-1];
                  dbz_q   <= start_dbz;
                  ovf_q   <= start_ovf;
                  busy_q  <= 1'b1;
                  state   <= BUSY;
`ifdef DIV_FAST_SPECIAL_EN
                  if (start_dbz || start_ovf) begin
                     state  <= DONE;
                     stop_q <= 1'b1;
                  end
`endif
               end
            end
            BUSY: begin
               if (!diff[DATA_W]) begin
                  rem_q <= diff[DATA_W-1:0];
                  quo_q <= {quo_q[DATA_W-2:0], 1'b1};
               end else begin
                  rem_q <= partial[DATA_W-1:0];
                  quo_q <= {quo_q[DATA_W-2:0], 1'b0};
               end
               cnt <= cnt + CW'(1);
               if (cnt == CW'(DATA_W - 1)) begin
                  state  <= DONE;
                  stop_q <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               stop_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               stop_q <= 1'b0;
            end
         endcase
      end
   end

   // Sign fix-up and RISC-V special-case overrides; results hold until the next start reloads.
   always_comb begin
      quo_out = (sgn_q && qsign_q && !dbz_q) ? -quo_q : quo_q;
      rem_out = (sgn_q && rsign_q) ? -rem_q : rem_q;
      if (dbz_q) begin
         quo_out = '1;
         rem_out = op1_q;
      end else if (ovf_q) begin
         quo_out = MIN_VAL;
         rem_out = '0;
      end
   end

   assign bus.div_busy = busy_q;
   assign bus.div_stop = stop_q;
   assign bus.div_quo  = quo_out;
   assign bus.div_rem  = rem_out;
endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed RV32M cases, cancel/reset scenarios and random operands
// checked against a plain-arithmetic reference model.
module tb_div;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   logic stop_seen;

   div_if #(.DATA_W(32)) bus ();

   div #(.DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      stop_seen = stop_seen | bus.div_stop;
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r, output logic special);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      special = 1'b0;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         special = 1'b1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = 32'd0;
         special = 1'b1;
      end else if (s) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic inject);
      logic [31:0] eq, er, q, r;
      logic        special;
      int          k, lat, stops, busy_n, exp_lat, exp_busy;
      model(a, b, s, eq, er, special);
`ifdef DIV_FAST_SPECIAL_EN
      exp_lat  = special ? 0 : 32;
      exp_busy = special ? 1 : 33;
`else
      exp_lat  = 32;
      exp_busy = 33;
`endif
      @(negedge clk);
      bus.div_start  = 1'b1;
      bus.div_signed = s;
      bus.div_op1    = a;
      bus.div_op2    = b;
      @(negedge clk);
      bus.div_start = 1'b0;
      k = 0; lat = -1; stops = 0; busy_n = 0; q = '0; r = '0;
      while (k < 100) begin
         if (bus.div_busy) busy_n++;
         if (bus.div_stop) begin
            stops++;
            lat = k;
            q = bus.div_quo;
            r = bus.div_rem;
         end
         if (!bus.div_busy) break;
         if (inject && k == 5) begin
            bus.div_start  = 1'b1;
            bus.div_signed = ~s;
            bus.div_op1    = 32'd55;
            bus.div_op2    = 32'd5;
         end else begin
            bus.div_start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      bus.div_start = 1'b0;
      check({tag, "_timeout"}, 32'(k < 100), 32'd1);
      check({tag, "_quo"}, q, eq);
      check({tag, "_rem"}, r, er);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_stop_pulses"}, 32'(stops), 32'd1);
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      stop_seen = 1'b0;
      rst_n = 1'b0;
      bus.div_start  = 1'b0;
      bus.div_cancel = 1'b0;
      bus.div_signed = 1'b0;
      bus.div_op1    = '0;
      bus.div_op2    = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_busy", 32'(bus.div_busy), 32'd0);
      check("reset_stop", 32'(bus.div_stop), 32'd0);
      check("reset_quo", bus.div_quo, 32'd0);
      check("reset_rem", bus.div_rem, 32'd0);

      run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
      run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      run_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
      run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("sdiv_zero", 32'h1234_5678, 32'd0, 1'b1, 1'b0);
      run_op("udiv_zero", 32'h1234_5678, 32'd0, 1'b0, 1'b0);
      run_op("sdiv_neg_zero", 32'h8765_4321, 32'd0, 1'b1, 1'b0);
      run_op("udiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("start_in_busy", 32'd100, 32'd7, 1'b0, 1'b1);

      // cancel after 10 iterations, with an ignored start mid-BUSY
      stop_seen = 1'b0;
      @(negedge clk);
      bus.div_start = 1'b1; bus.div_signed = 1'b0;
      bus.div_op1 = 32'd1000; bus.div_op2 = 32'd3;
      tick();
      bus.div_start = 1'b0;
      repeat (4) tick();
      bus.div_start = 1'b1; bus.div_op1 = 32'd99; bus.div_op2 = 32'd9;
      tick();
      bus.div_start = 1'b0;
      repeat (5) tick();
      bus.div_cancel = 1'b1;
      tick();
      bus.div_cancel = 1'b0;
      check("cancel_busy", 32'(bus.div_busy), 32'd0);
      repeat (3) tick();
      check("cancel_no_stop", 32'(stop_seen), 32'd0);
      run_op("after_cancel_17_5", 32'd17, 32'd5, 1'b0, 1'b0);

      // start and cancel together: no operation begins
      stop_seen = 1'b0;
      @(negedge clk);
      bus.div_start = 1'b1; bus.div_cancel = 1'b1;
      bus.div_op1 = 32'd50; bus.div_op2 = 32'd5;
      tick();
      bus.div_start = 1'b0; bus.div_cancel = 1'b0;
      check("start_cancel_busy", 32'(bus.div_busy), 32'd0);
      repeat (40) tick();
      check("start_cancel_no_stop", 32'(stop_seen), 32'd0);

      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         if (i % 3 == 0) b = b >> $urandom_range(0, 31);
         run_op("random", a, b, 1'($urandom_range(0, 1)), 1'b0);
      end

      // reset mid-operation clears everything at once
      @(negedge clk);
      bus.div_start = 1'b1; bus.div_signed = 1'b0;
      bus.div_op1 = 32'd1000; bus.div_op2 = 32'd3;
      @(negedge clk);
      bus.div_start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(bus.div_busy), 32'd0);
      check("rst_mid_stop", 32'(bus.div_stop), 32'd0);
      check("rst_mid_quo", bus.div_quo, 32'd0);
      check("rst_mid_rem", bus.div_rem, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_reset", 32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
